// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// rv32i_pkg : shared constants and state encoding for the fetch front-end
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
//------------------------------------------------------------------------------
// instruction_fetch_if : cache, decode and redirect signals of the fetch stage
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req;
  logic [DATA_W-1:0] cache_instr;
  logic              cache_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output fetch_addr, fetch_req, if_valid, if_instr, if_pc,
    input  cache_instr, cache_ready, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  fetch_addr, fetch_req, if_valid, if_instr, if_pc,
    output cache_instr, cache_ready, id_ready, redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// fetch_fifo : 2-entry shift FIFO whose head is a register driving decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] din,
  output      logic [WIDTH-1:0] dout,
  output      logic [1:0]       count,
  output      logic             valid
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  // Flushing only clears the count; the head keeps its last contents visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= RESET_DATA;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) r_head <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_head;
  assign count = r_count;
  assign valid = (r_count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// instruction_fetch : PC register, fetch state machine and redirect handling
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input wire logic             iCLK,
  input wire logic             iRST,
  instruction_fetch_if.master  bus
);

  localparam int                       FIFO_W     = ADDR_W + DATA_W;
  localparam logic [FIFO_W-1:0]        FIFO_RESET = {{ADDR_W{1'b0}}, DATA_W'(NOP_INSTR)};
  localparam logic [ADDR_W-1:0]        STEP       = ADDR_W'(PC_STEP);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic              r_fetch_req;

  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic [1:0]        w_count;
  logic [1:0]        w_count_next;
  logic              w_valid;
  logic [FIFO_W-1:0] w_head;

  // Redirect wins over everything, so it masks both enqueue and dequeue.
  assign w_flush = bus.redirect_valid;
  assign w_push  = (r_state == FETCH) && bus.cache_ready && !w_flush;
  assign w_pop   = w_valid && bus.id_ready && !w_flush;

  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop)      w_count_next = w_count + 2'd1;
    else if (!w_push && w_pop) w_count_next = w_count - 2'd1;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state      <= IDLE;
      r_fetch_addr <= RESET_PC;
      r_fetch_req  <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_state      <= DRAIN;
      r_fetch_addr <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      r_fetch_req  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state     <= FETCH;
          r_fetch_req <= 1'b1;
        end
        FETCH: begin
          if (w_push) begin
            r_fetch_addr <= r_fetch_addr + STEP;
            if (w_count_next == 2'd2) begin
              r_state     <= FULL;
              r_fetch_req <= 1'b0;
            end
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state     <= FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        DRAIN: begin
          r_state     <= FETCH;
          r_fetch_req <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_fetch_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH      (FIFO_W),
    .RESET_DATA (FIFO_RESET)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ({r_fetch_addr, bus.cache_instr}),
    .dout  (w_head),
    .count (w_count),
    .valid (w_valid)
  );

  assign bus.fetch_addr = r_fetch_addr;
  assign bus.fetch_req  = r_fetch_req;
  assign bus.if_valid   = w_valid;
  assign bus.if_pc      = w_head[FIFO_W-1:DATA_W];
  assign bus.if_instr   = w_head[DATA_W-1:0];

endmodule

`default_nettype wire
